instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the PC and drives the word address to the combinational instruction memory; memory returns data in the same cycle.
- Captures {pc, instruction} pairs into a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the FIFO and reload the PC.

---
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction memory and
// buffers {pc, instr} pairs in a prefetch FIFO for decode. Optional macro: FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]   pc;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_q    [FIFO_DEPTH];
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic          push;
  logic          pop;
  logic          blocked;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;

  // Sticky until reset or an aligned redirect; while set, fetch is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else if (redirect_valid) begin
      misaligned <= |redirect_pc[1:0];
    end
  end

  assign blocked          = misaligned;
  assign fetch_misaligned = misaligned;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign blocked             = 1'b0;
`endif

  assign imem_addr = pc;

  // Push looks only at the registered count, so a full FIFO never pushes even while popping.
  assign push = fetch_en & ~redirect_valid & ~blocked & (count < DEPTH_C);
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC_ALIGNED;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wptr]    <= pc;
      instr_q[wptr] <= imem_rd;
    end
  end

  always_comb begin
    out_valid = (count != '0);
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = instr_q[rptr];
      out_pc    = pc_q[rptr];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; memory word at byte address a is 32'h1000 + a/4.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_fetch_en;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rd;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misaligned;
  logic w_fetch_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  assign imem_rd   = mem_word(imem_addr);
  assign w_imem_rd = mem_word(w_imem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .fetch_en(w_fetch_en), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned(w_fetch_misaligned)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    fetch_en         = 1'b0;
    out_ready        = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    w_fetch_en       = 1'b0;
    w_out_ready      = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_w_addr", w_imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif

    // Streaming at one instruction per cycle.
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("stream_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("stream_pc%0d", k), out_pc, 32'(4 * k));
      check($sformatf("stream_instr%0d", k), out_instr, 32'h1000 + 32'(k));
    end

    // Asynchronous reset mid-stream empties the FIFO before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_pc", out_pc, 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    do_reset();

    // Backpressure: fill to depth, then drain without gaps.
    fetch_en = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("bp_addr_frozen", imem_addr, 32'h10);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_full_pop_no_push", imem_addr, 32'h10);
    check("bp_drain_pc0", out_pc, 32'h4);
    step();
    check("bp_drain_pc1", out_pc, 32'h8);
    step();
    check("bp_drain_pc2", out_pc, 32'hC);
    step();
    check("bp_drain_pc3", out_pc, 32'h10);
    check("bp_drain_instr3", out_instr, 32'h1004);
    step();
    check("bp_drain_pc4", out_pc, 32'h14);
    check("bp_drain_valid4", 32'(out_valid), 32'd1);

    // Redirect flushes three buffered entries.
    do_reset();
    fetch_en = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("rd_pre_addr", imem_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(out_valid), 32'd0);
    check("rd_flush_addr", imem_addr, 32'h200);
    step();
    check("rd_first_valid", 32'(out_valid), 32'd1);
    check("rd_first_pc", out_pc, 32'h200);
    check("rd_first_instr", out_instr, 32'h1080);

    // Redirect while the head (pc 8) is being accepted.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("rp_head_pc", out_pc, 32'h8);
    check("rp_head_valid", 32'(out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("rp_after_valid", 32'(out_valid), 32'd0);
    step();
    check("rp_new_pc0", out_pc, 32'h40);
    step();
    check("rp_new_pc1", out_pc, 32'h44);

`ifndef FETCH_MISALIGN_CHECK_EN
    // Without the check, low redirect bits are dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h207;
    step();
    redirect_valid = 1'b0;
    check("align_force_addr", imem_addr, 32'h204);
    step();
    check("align_force_pc", out_pc, 32'h204);
`endif

    // PC wrap-around and fetch_en=0 drain on the high-reset-PC instance.
    do_reset();
    w_fetch_en  = 1'b1;
    w_out_ready = 1'b1;
    step();
    check("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
    check("wrap_instr0", w_out_instr, 32'h4000_0FFE);
    step();
    check("wrap_pc1", w_out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", w_out_pc, 32'h0000_0000);
    check("wrap_instr2", w_out_instr, 32'h1000);
    check("wrap_addr", w_imem_addr, 32'h4);
    w_fetch_en  = 1'b0;
    w_out_ready = 1'b0;
    step();
    check("hold_addr", w_imem_addr, 32'h4);
    check("hold_valid", 32'(w_out_valid), 32'd1);
    w_out_ready = 1'b1;
    step();
    check("drain_valid", 32'(w_out_valid), 32'd0);
    check("drain_instr", w_out_instr, 32'h0);
    check("drain_addr", w_imem_addr, 32'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect sets a sticky flag and stalls fetch.
    do_reset();
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    check("mis_valid0", 32'(out_valid), 32'd0);
    step();
    step();
    check("mis_flag_sticky", 32'(fetch_misaligned), 32'd1);
    check("mis_valid2", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("mis_clear", 32'(fetch_misaligned), 32'd0);
    check("mis_clear_valid", 32'(out_valid), 32'd0);
    step();
    check("mis_resume_pc", out_pc, 32'h100);
    check("mis_resume_instr", out_instr, 32'h1040);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
